// File: rtl/spectrum_uart_tx.sv
// spectrum_uart_tx: 8N1 serial transmitter for spectrum frames.
// Each accepted request becomes a 5-byte packet, sent LSB first:
//   HEADER, frec[15:8], frec[7:0], {4'h0, amp_sat}, XOR checksum.
// The FSM advances on the accept edge. tx is registered from the FSM output
// decode, so the line lags the FSM by one cycle. As a result, tx falls one
// edge after accept, and busy/done line up with the end of the FSM's final
// stop bit.
// BAUD must be >= 2.
module spectrum_uart_tx #(
  parameter int unsigned BAUD    = 1250,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter logic [3:0]  AMP_MAX = 4'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] frec,
  input  logic [3:0]  amp,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   CW        = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  // Request fields, frozen for the whole packet.
  typedef struct packed {
    logic [15:0] frec;
    logic [3:0]  amp;
    logic [7:0]  csum;
  } pkt_t;

  state_t        state_q, state_d;
  pkt_t          pkt_q;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic          accept;
  logic          baud_end;
  logic          last_bit;
  logic          last_byte;
  logic [3:0]    amp_sat;
  logic [7:0]    csum_in;
  logic [7:0]    cur_byte;
  logic          tx_d;
  logic          done_d;

  assign accept    = (state_q == IDLE) && start;
  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign last_bit  = (bit_idx == 3'd7);
  assign last_byte = (byte_idx == 3'd4);
  assign amp_sat   = (amp > AMP_MAX) ? AMP_MAX : amp;
  assign csum_in   = frec[15:8] ^ frec[7:0] ^ {4'h0, amp_sat};
  assign busy      = (state_q != IDLE);

  // Capture the request on accept; later input changes cannot reach the packet.
  always_ff @(posedge clk) begin
    if (reset)       pkt_q <= '0;
    else if (accept) pkt_q <= '{frec: frec, amp: amp_sat, csum: csum_in};
  end

  // Select the byte currently on the wire.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = pkt_q.frec[15:8];
      3'd2:    cur_byte = pkt_q.frec[7:0];
      3'd3:    cur_byte = {4'h0, pkt_q.amp};
      default: cur_byte = pkt_q.csum;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: every bit lasts BAUD cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)                state_d = START_BIT;
      START_BIT: if (baud_end)             state_d = DATA;
      DATA:      if (baud_end && last_bit) state_d = STOP_BIT;
      STOP_BIT:  if (baud_end)             state_d = last_byte ? IDLE : START_BIT;
      default:                             state_d = IDLE;
    endcase
  end

  // Output decode: next line level and the end-of-packet strobe.
  always_comb begin
    tx_d   = 1'b1;
    done_d = 1'b0;
    case (state_q)
      IDLE:      tx_d = 1'b1;
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = cur_byte[bit_idx];
      STOP_BIT: begin
        tx_d   = 1'b1;
        done_d = baud_end && last_byte;
      end
      default:   tx_d = 1'b1;
    endcase
  end

  // Registered line and done pulse. Reset forces the line idle immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx   <= 1'b1;
      done <= 1'b0;
    end else begin
      tx   <= tx_d;
      done <= done_d;
    end
  end

  // Baud, bit and byte counters. All clear on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else if (state_q != IDLE) begin
      baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      if (baud_end) begin
        case (state_q)
          DATA:     bit_idx <= bit_idx + 1'b1;
          STOP_BIT: begin
            bit_idx  <= '0;
            byte_idx <= last_byte ? 3'd0 : byte_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spectrum_uart_tx.sv
// Bench for spectrum_uart_tx at BAUD=4.
// A line decoder pops expected bytes from a scoreboard filled when each
// packet is requested. Directed steps cover reset, framing, saturation,
// busy-ignore, mid-packet abort and back-to-back packets.
module tb_spectrum_uart_tx;

  localparam int unsigned BAUD = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] frec;
  logic [3:0]  amp;
  logic        tx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];

  spectrum_uart_tx #(.BAUD(BAUD), .HEADER(8'hA5), .AMP_MAX(4'd10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .frec  (frec),
    .amp   (amp),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Line decoder: samples mid-bit on negedges and aborts a frame on reset.
  int         mon_p   = 0;
  bit         mon_act = 1'b0;
  logic [7:0] mon_byte;
  logic [7:0] exp_b;
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1'b1;
          mon_p   = 0;
        end
      end else begin
        mon_p++;
        if (mon_p % BAUD == BAUD / 2) begin
          if (mon_p / BAUD >= 1 && mon_p / BAUD <= 8) begin
            mon_byte[mon_p / BAUD - 1] = tx;
          end else if (mon_p / BAUD == 9) begin
            chk("stop_bit", 32'(tx), 32'd1);
            chk("byte_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
              exp_b = sb.pop_front();
              chk("rx_byte", 32'(mon_byte), 32'(exp_b));
            end
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_pkt(input logic [15:0] f, input logic [3:0] a);
    logic [3:0] as;
    as = (a > 4'd10) ? 4'd10 : a;
    sb.push_back(8'hA5);
    sb.push_back(f[15:8]);
    sb.push_back(f[7:0]);
    sb.push_back({4'h0, as});
    sb.push_back(f[15:8] ^ f[7:0] ^ {4'h0, as});
  endtask

  // Send one packet and check busy/done timing relative to the accept edge.
  // repulse_at: cycle at which start is pulsed again and inputs are scrambled.
  // reset_at:   cycle at which reset aborts the packet (0 = none).
  task automatic run_pkt(input logic [15:0] f, input logic [3:0] a,
                         input int repulse_at, input int reset_at);
    int bad_busy = 0;
    int done_cnt = 0;
    int done_at  = -1;
    int last_i;
    push_pkt(f, a);
    frec  = f;
    amp   = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_tx_high", 32'(tx), 32'd1);
    last_i = (reset_at > 0) ? reset_at + 20 : 210;
    for (int i = 1; i <= last_i; i++) begin
      @(negedge clk);
      if (i == 1) chk("first_start_bit", 32'(tx), 32'd0);
      if (done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      if (reset_at > 0) begin
        if (i < reset_at && busy !== 1'b1) bad_busy++;
        if (i == reset_at) reset = 1'b1;
        if (i == reset_at + 1) begin
          chk("abort_tx", 32'(tx), 32'd1);
          chk("abort_busy", 32'(busy), 32'd0);
        end
        if (i == reset_at + 2) begin
          reset = 1'b0;
          sb.delete();
        end
      end else begin
        if (i < 200 && busy !== 1'b1) bad_busy++;
        if (i >= 200 && busy !== 1'b0) bad_busy++;
      end
      if (repulse_at > 0 && i == repulse_at) begin
        start = 1'b1;
        frec  = ~f;
        amp   = a ^ 4'h5;
      end
      if (repulse_at > 0 && i == repulse_at + 1) begin
        start = 1'b0;
        frec  = 16'h5A5A;
      end
    end
    chk("busy_window", 32'(bad_busy), 32'd0);
    if (reset_at > 0) begin
      chk("abort_no_done", 32'(done_cnt), 32'd0);
    end else begin
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("done_cycle", 32'(done_at), 32'd200);
      chk("sb_drained", 32'(sb.size()), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int any_low = 0;
    int nd = 0;
    int nf = 0;
    int d_at[3];
    int f_at[2];

    // Reset state and idle line.
    reset = 1'b1;
    start = 1'b0;
    frec  = '0;
    amp   = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) any_low++;
    end
    chk("idle_line", 32'(any_low), 32'd0);

    // Basic packet, then amplitude saturation and the exact limit.
    run_pkt(16'h1234, 4'h9, 0, 0);
    run_pkt(16'h00FF, 4'hF, 0, 0);
    run_pkt(16'h00FF, 4'hA, 0, 0);

    // start while busy is ignored; inputs changed mid-packet.
    run_pkt(16'hBEEF, 4'h3, 50, 0);
    repeat (20) @(negedge clk);
    chk("no_second_pkt", 32'(busy), 32'd0);
    chk("no_extra_bytes", 32'(sb.size()), 32'd0);

    // Abort at cycle 90, then a fresh packet.
    run_pkt(16'hC3C3, 4'h5, 0, 90);
    run_pkt(16'h0F0F, 4'h7, 0, 0);

    // start held high: back-to-back packets with one idle cycle between.
    push_pkt(16'hFFFF, 4'h0);
    push_pkt(16'hFFFF, 4'h0);
    push_pkt(16'hFFFF, 4'h0);
    frec  = 16'hFFFF;
    amp   = 4'h0;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 700 && nd < 3; c++) begin
      @(negedge clk);
      if (tx === 1'b0 && nd > 0 && nd < 3 && nf < nd) begin
        f_at[nf] = c;
        nf++;
      end
      if (done === 1'b1) begin
        d_at[nd] = c;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd3);
    chk("b2b_fall_count", 32'(nf), 32'd2);
    if (nd == 3 && nf == 2) begin
      chk("b2b_first_done", 32'(d_at[0]), 32'd200);
      chk("b2b_period_1", 32'(d_at[1] - d_at[0]), 32'd201);
      chk("b2b_period_2", 32'(d_at[2] - d_at[1]), 32'd201);
      chk("b2b_gap_1", 32'(f_at[0] - d_at[0]), 32'd2);
      chk("b2b_gap_2", 32'(f_at[1] - d_at[1]), 32'd2);
    end
    repeat (10) @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
